decoder_8b10b: RTL and testbench
================================

Name: decoder_8b10b

Overview:
Receive-side 8b/10b decoder. Its transmit-side partner is encoder_8b10b.
- Takes one 10-bit symbol per valid cycle and returns the 8-bit byte and a K (control) flag.
- Tracks running disparity (RD) and flags code-violation and disparity errors.
- Sits between the PCIe PHY deserialiser/symbol aligner and the link-layer receive path. Output is registered, one-cycle latency.

Parameters:
RD_INIT, 1'b0, RD after reset: 0 = RD-, 1 = RD+.
ERR_CNT_W, 16, width of the saturating error counter (used only with the optional feature).

Ports:
clk_i  input  1  clock; all logic on rising edge.
rst_i  input  1  synchronous, active-high reset.
valid_i  input  1  encoded_8b10b_symbol_i carries a symbol this cycle.
encoded_8b10b_symbol_i  input  10  symbol; [9:4]=abcdei (a at bit 9, sent first), [3:0]=fghj (f at bit 3).
valid_o  output  1  outputs below are valid this cycle.
data_o  output  8  decoded byte; [7:5]=HGF, [4:0]=EDCBA.
is_special_k_o  output  1  symbol decoded as a K code.
code_err_o  output  1  symbol is not a legal 8b/10b code group.
disp_err_o  output  1  symbol violates the current RD.
rd_o  output  1  current RD state (0 = RD-, 1 = RD+).

Behaviour:
Reset:
- Applies on the clock edge when rst_i=1 and overrides valid_i.
- valid_o=0, data_o=8'h00, is_special_k_o=0, code_err_o=0, disp_err_o=0, rd_o=RD_INIT.
- Reset asserted mid-stream drops any in-flight symbol; the first symbol after release is checked against RD_INIT.

Latency and handshake:
- Symbol sampled at edge N with valid_i=1 produces valid_o=1 and its results at edge N+1.
- No backpressure. Back-to-back symbols are accepted every cycle.

valid_i=0:
- valid_o=0, code_err_o=0, disp_err_o=0.
- data_o, is_special_k_o and rd_o hold their last values.

Decode:
- 5b/6b and 3b/4b lookups per IEEE 802.3 Clause 36, both RD columns.
- Alternate D.x.A7 forms (0111/1000) decode to HGF=111.
- Legal K codes: K28.0–K28.7, K23.7, K27.7, K29.7, K30.7. They decode to their byte (e.g. K28.5 -> 8'hBC) with is_special_k_o=1.

Code error (code_err_o=1):
- 6b sub-block ones count not in {2,3,4}, or 4b sub-block ones count not in {1,2,3}.
- 6b or 4b pattern absent from the table.
- abcdei=001111/110000 combined with an fghj not valid for a K28 code.
- On error, data_o = best-effort table output, else 8'h00; is_special_k_o=0.

RD update, per sub-block (6b first, then 4b using the intermediate RD):
- Result RD+ if the sub-block has more ones than zeros, or equals 000111 (6b) / 0011 (4b).
- Result RD- if more zeros than ones, or equals 111000 / 1100.
- Otherwise RD is unchanged.

Disparity error (disp_err_o=1), checked per sub-block against the entering RD:
- Fault if the sub-block would drive RD+ while the entering RD is already RD+.
- Fault if it would drive RD- while the entering RD is already RD-.
- RD is still updated from the received sub-block contents, so the decoder resynchronises after one bad symbol.

Error independence:
- code_err_o and disp_err_o are independent and may both be 1.
- When a sub-block has an illegal ones count, RD is still updated by the majority rule.

rd_o always reflects RD after the last accepted symbol.

Optional Feature:
Macro DECODER_8B10B_ERR_CNT_EN.
- Defined: adds input err_cnt_clr_i (1) and output err_count_o (ERR_CNT_W).
  - Counter increments by 1 the cycle after any accepted symbol with code_err or disp_err (a symbol with both counts once).
  - Saturates at all-ones.
  - Reset to 0 by rst_i.
  - err_cnt_clr_i=1 forces 0 next edge and takes priority over a simultaneous increment.
- Undefined: neither port exists and no counter logic is built.

Test Plan:
1. Reset (RD_INIT=0), valid_i=1, symbol 10'h0FA (K28.5 RD-) -> next cycle data_o=8'hBC, is_special_k_o=1, both errors 0, rd_o=1. Then 10'h305 (K28.5 RD+) -> 8'hBC, K=1, no errors, rd_o=0.
2. From RD-, symbols 10'h274 (D0.0) then 10'h2AA (D21.5) -> data_o 8'h00 then 8'hB5, K=0, no errors, rd_o stays 0.
3. Reset, then 10'h305 -> data_o=8'hBC, K=1, disp_err_o=1, code_err_o=0, rd_o=0. Then 10'h0FA -> no errors (resync).
4. Symbol 10'h000 then 10'h3FF -> code_err_o=1 each cycle, is_special_k_o=0. valid_i=0 gap -> valid_o=0, error flags 0, rd_o held.
5. Stream of valid symbols, rst_i=1 for one cycle mid-stream -> next cycle all outputs at reset values. The first symbol after release is checked against RD-.
6. With DECODER_8B10B_ERR_CNT_EN and ERR_CNT_W=2: five error symbols -> err_count_o 1,2,3,3,3. Pulse err_cnt_clr_i together with an error symbol -> 0.

Source files
------------

// File: rtl/decoder_8b10b_if.sv
// ---------------------------------------------------------------------------
// decoder_8b10b_if
// Symbol-in / byte-out bundle for the 8b/10b receive decoder.
//   valid_i                 : symbol present this cycle (master -> decoder)
//   encoded_8b10b_symbol_i  : [9:4]=abcdei (a at bit 9), [3:0]=fghj
//   valid_o                 : decoded results valid this cycle
//   data_o                  : decoded byte, [7:5]=HGF, [4:0]=EDCBA
//   is_special_k_o          : symbol decoded as a K code
//   code_err_o              : symbol is not a legal code group
//   disp_err_o              : symbol violates the running disparity
//   rd_o                    : running disparity after last accepted symbol
// Modports: slave = decoder side, master = symbol source / result sink.
// ---------------------------------------------------------------------------
interface decoder_8b10b_if;
  logic       valid_i;
  logic [9:0] encoded_8b10b_symbol_i;
  logic       valid_o;
  logic [7:0] data_o;
  logic       is_special_k_o;
  logic       code_err_o;
  logic       disp_err_o;
  logic       rd_o;

  modport slave (
    input  valid_i,
    input  encoded_8b10b_symbol_i,
    output valid_o,
    output data_o,
    output is_special_k_o,
    output code_err_o,
    output disp_err_o,
    output rd_o
  );

  modport master (
    output valid_i,
    output encoded_8b10b_symbol_i,
    input  valid_o,
    input  data_o,
    input  is_special_k_o,
    input  code_err_o,
    input  disp_err_o,
    input  rd_o
  );
endinterface

// File: rtl/decoder_8b10b.sv
// ---------------------------------------------------------------------------
// decoder_8b10b
// Receive-side 8b/10b decoder (IEEE 802.3 Clause 36 code tables). One symbol
// per valid cycle, registered results one cycle later, no backpressure.
// Tracks running disparity and flags code and disparity errors.
//
// Ports:
//   clk_i          : clock, rising edge
//   rst_i          : synchronous active-high reset
//   bus            : decoder_8b10b_if.slave (symbol in, byte/flags/RD out)
//   err_cnt_clr_i  : clear error counter (only with DECODER_8B10B_ERR_CNT_EN)
//   err_count_o    : saturating error count (only with DECODER_8B10B_ERR_CNT_EN)
//
// Parameters:
//   RD_INIT   : running disparity after reset (0 = RD-, 1 = RD+)
//   ERR_CNT_W : width of the optional error counter
//
// Optional feature macro: DECODER_8B10B_ERR_CNT_EN
// ---------------------------------------------------------------------------
module decoder_8b10b #(
  parameter logic        RD_INIT   = 1'b0,
  parameter int unsigned ERR_CNT_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
`ifdef DECODER_8B10B_ERR_CNT_EN
  input  logic                 err_cnt_clr_i,
  output logic [ERR_CNT_W-1:0] err_count_o,
`endif
  decoder_8b10b_if.slave       bus
);

  // Population count of a 6-bit sub-block.
  function automatic logic [2:0] pop6(input logic [5:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 6; i++) n = n + {2'b00, v[i]};
    return n;
  endfunction

  // Population count of a 4-bit sub-block.
  function automatic logic [2:0] pop4(input logic [3:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 4; i++) n = n + {2'b00, v[i]};
    return n;
  endfunction

  // 6b -> 5b lookup, both RD columns. Returns {found, EDCBA}.
  // The K28 sub-blocks (001111/110000) map to 28 as well.
  function automatic logic [5:0] dec6(input logic [5:0] s);
    logic [5:0] r;
    r = 6'd0;
    unique case (s)
      6'b100111, 6'b011000: r = {1'b1, 5'd0};
      6'b011101, 6'b100010: r = {1'b1, 5'd1};
      6'b101101, 6'b010010: r = {1'b1, 5'd2};
      6'b110001:            r = {1'b1, 5'd3};
      6'b110101, 6'b001010: r = {1'b1, 5'd4};
      6'b101001:            r = {1'b1, 5'd5};
      6'b011001:            r = {1'b1, 5'd6};
      6'b111000, 6'b000111: r = {1'b1, 5'd7};
      6'b111001, 6'b000110: r = {1'b1, 5'd8};
      6'b100101:            r = {1'b1, 5'd9};
      6'b010101:            r = {1'b1, 5'd10};
      6'b110100:            r = {1'b1, 5'd11};
      6'b001101:            r = {1'b1, 5'd12};
      6'b101100:            r = {1'b1, 5'd13};
      6'b011100:            r = {1'b1, 5'd14};
      6'b010111, 6'b101000: r = {1'b1, 5'd15};
      6'b011011, 6'b100100: r = {1'b1, 5'd16};
      6'b100011:            r = {1'b1, 5'd17};
      6'b010011:            r = {1'b1, 5'd18};
      6'b110010:            r = {1'b1, 5'd19};
      6'b001011:            r = {1'b1, 5'd20};
      6'b101010:            r = {1'b1, 5'd21};
      6'b011010:            r = {1'b1, 5'd22};
      6'b111010, 6'b000101: r = {1'b1, 5'd23};
      6'b110011, 6'b001100: r = {1'b1, 5'd24};
      6'b100110:            r = {1'b1, 5'd25};
      6'b010110:            r = {1'b1, 5'd26};
      6'b110110, 6'b001001: r = {1'b1, 5'd27};
      6'b001110, 6'b001111,
      6'b110000:            r = {1'b1, 5'd28};
      6'b101110, 6'b010001: r = {1'b1, 5'd29};
      6'b011110, 6'b100001: r = {1'b1, 5'd30};
      6'b101011, 6'b010100: r = {1'b1, 5'd31};
      default:              r = 6'd0;
    endcase
    return r;
  endfunction

  // 4b -> 3b lookup for data characters, including primary and alternate
  // x.7 forms. Returns {found, HGF}.
  function automatic logic [3:0] dec4(input logic [3:0] s);
    logic [3:0] r;
    r = 4'd0;
    unique case (s)
      4'b1011, 4'b0100:                   r = {1'b1, 3'd0};
      4'b1001:                            r = {1'b1, 3'd1};
      4'b0101:                            r = {1'b1, 3'd2};
      4'b1100, 4'b0011:                   r = {1'b1, 3'd3};
      4'b1101, 4'b0010:                   r = {1'b1, 3'd4};
      4'b1010:                            r = {1'b1, 3'd5};
      4'b0110:                            r = {1'b1, 3'd6};
      4'b1110, 4'b0001, 4'b0111, 4'b1000: r = {1'b1, 3'd7};
      default:                            r = 4'd0;
    endcase
    return r;
  endfunction

  // fghj that may follow abcdei=001111 in a K28.y symbol. The 110000 form is
  // the bitwise complement of the whole symbol, so its fghj is inverted
  // before this lookup. Returns {found, y}.
  function automatic logic [3:0] dec4_k28(input logic [3:0] s);
    logic [3:0] r;
    r = 4'd0;
    unique case (s)
      4'b0100: r = {1'b1, 3'd0};
      4'b1001: r = {1'b1, 3'd1};
      4'b0101: r = {1'b1, 3'd2};
      4'b0011: r = {1'b1, 3'd3};
      4'b0010: r = {1'b1, 3'd4};
      4'b1010: r = {1'b1, 3'd5};
      4'b0110: r = {1'b1, 3'd6};
      4'b1000: r = {1'b1, 3'd7};
      default: r = 4'd0;
    endcase
    return r;
  endfunction

  logic       valid_q, valid_d;
  logic [7:0] data_q, data_d;
  logic       k_q, k_d;
  logic       code_err_q, code_err_d;
  logic       disp_err_q, disp_err_d;
  logic       rd_q, rd_d;

  logic [5:0] s6;
  logic [3:0] s4;
  logic [2:0] n6, n4;
  logic [5:0] d6;
  logic [3:0] d4, dk;
  logic       is_k28_6b;
  logic       k_x7;
  logic       code_err_w;
  logic       disp_err_w;
  logic       k_w;
  logic [7:0] data_w;
  logic       pos6, neg6, pos4, neg4;
  logic       flt6, flt4;
  logic       rd_mid, rd_end;

  assign s6 = bus.encoded_8b10b_symbol_i[9:4];
  assign s4 = bus.encoded_8b10b_symbol_i[3:0];
  assign n6 = pop6(s6);
  assign n4 = pop4(s4);
  assign d6 = dec6(s6);
  assign d4 = dec4(s4);

  assign is_k28_6b = (s6 == 6'b001111) || (s6 == 6'b110000);
  assign dk        = dec4_k28((s6 == 6'b110000) ? ~s4 : s4);

  // K23.7/K27.7/K29.7/K30.7: the D23/27/29/30 6b code followed by the
  // alternate 7 form that would be illegal for data at that RD.
  assign k_x7 = d6[5] &&
                ((d6[4:0] == 5'd23) || (d6[4:0] == 5'd27) ||
                 (d6[4:0] == 5'd29) || (d6[4:0] == 5'd30)) &&
                (((n6 > 3'd3) && (s4 == 4'b1000)) ||
                 ((n6 < 3'd3) && (s4 == 4'b0111)));

  // Table misses already cover illegal ones counts; the counts are kept
  // explicit so the rule reads directly.
  assign code_err_w = (n6 < 3'd2) || (n6 > 3'd4) ||
                      (n4 < 3'd1) || (n4 > 3'd3) ||
                      !d6[5] || !d4[3] ||
                      (is_k28_6b && !dk[3]);

  assign k_w = !code_err_w && ((is_k28_6b && dk[3]) || k_x7);

  always_comb begin
    data_w = 8'h00;
    if (is_k28_6b && dk[3]) begin
      data_w = {dk[2:0], 5'd28};
    end else if (d6[5] && d4[3]) begin
      data_w = {d4[2:0], d6[4:0]};
    end
  end

  // Running disparity, 6b first then 4b from the intermediate RD.
  // 000111/111000 and 0011/1100 are balanced but pin RD to a known side.
  assign pos6   = (n6 > 3'd3) || (s6 == 6'b000111);
  assign neg6   = (n6 < 3'd3) || (s6 == 6'b111000);
  assign flt6   = ((n6 > 3'd3) && rd_q) || ((n6 < 3'd3) && !rd_q);
  assign rd_mid = pos6 ? 1'b1 : (neg6 ? 1'b0 : rd_q);

  assign pos4   = (n4 > 3'd2) || (s4 == 4'b0011);
  assign neg4   = (n4 < 3'd2) || (s4 == 4'b1100);
  assign flt4   = ((n4 > 3'd2) && rd_mid) || ((n4 < 3'd2) && !rd_mid);
  assign rd_end = pos4 ? 1'b1 : (neg4 ? 1'b0 : rd_mid);

  assign disp_err_w = flt6 || flt4;

  always_comb begin
    valid_d    = 1'b0;
    code_err_d = 1'b0;
    disp_err_d = 1'b0;
    data_d     = data_q;
    k_d        = k_q;
    rd_d       = rd_q;
    if (bus.valid_i) begin
      valid_d    = 1'b1;
      code_err_d = code_err_w;
      disp_err_d = disp_err_w;
      data_d     = data_w;
      k_d        = k_w;
      rd_d       = rd_end;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q    <= 1'b0;
      data_q     <= 8'h00;
      k_q        <= 1'b0;
      code_err_q <= 1'b0;
      disp_err_q <= 1'b0;
      rd_q       <= RD_INIT;
    end else begin
      valid_q    <= valid_d;
      data_q     <= data_d;
      k_q        <= k_d;
      code_err_q <= code_err_d;
      disp_err_q <= disp_err_d;
      rd_q       <= rd_d;
    end
  end

  assign bus.valid_o        = valid_q;
  assign bus.data_o         = data_q;
  assign bus.is_special_k_o = k_q;
  assign bus.code_err_o     = code_err_q;
  assign bus.disp_err_o     = disp_err_q;
  assign bus.rd_o           = rd_q;

`ifdef DECODER_8B10B_ERR_CNT_EN
  localparam logic [ERR_CNT_W-1:0] CNT_MAX = {ERR_CNT_W{1'b1}};
  localparam logic [ERR_CNT_W-1:0] CNT_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  // Updates on the same edge as the error flags; clear wins over increment.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_cnt_clr_i) begin
      err_cnt_d = '0;
    end else if (bus.valid_i && (code_err_w || disp_err_w) &&
                 (err_cnt_q != CNT_MAX)) begin
      err_cnt_d = err_cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_count_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_decoder_8b10b.sv
// ---------------------------------------------------------------------------
// tb_decoder_8b10b
// Self-checking bench for decoder_8b10b. A reference model decodes symbols by
// searching the 8b/10b encode tables and applying the disparity rules with
// ones-count arithmetic; a compare process checks every DUT output against it
// on each falling edge. Directed vectors also carry literal expectations.
// Error-counter checks are compiled when DECODER_8B10B_ERR_CNT_EN is defined.
// ---------------------------------------------------------------------------
module tb_decoder_8b10b;

  localparam logic RD_INIT = 1'b0;

  localparam logic [5:0] E6N [0:31] = '{
    6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
    6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
    6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
    6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
  localparam logic [5:0] E6P [0:31] = '{
    6'b011000, 6'b100010, 6'b010010, 6'b110001, 6'b001010, 6'b101001, 6'b011001, 6'b000111,
    6'b000110, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b101000,
    6'b100100, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b000101,
    6'b001100, 6'b100110, 6'b010110, 6'b001001, 6'b001110, 6'b010001, 6'b100001, 6'b010100};
  localparam logic [3:0] E4N [0:7] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
  localparam logic [3:0] E4P [0:7] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b0001};
  // fghj of K28.y after 001111 (RD- column) and after 110000 (RD+ column)
  localparam logic [3:0] K4N [0:7] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011, 4'b0010, 4'b1010, 4'b0110, 4'b1000};
  localparam logic [3:0] K4P [0:7] = '{4'b1011, 4'b0110, 4'b1010, 4'b1100, 4'b1101, 4'b0101, 4'b1001, 4'b0111};
  // K23.7, K27.7, K29.7, K30.7 in both columns
  localparam logic [9:0] KX7 [0:7] = '{
    10'b1110101000, 10'b0001010111, 10'b1101101000, 10'b0010010111,
    10'b1011101000, 10'b0100010111, 10'b0111101000, 10'b1000010111};

  typedef struct packed {
    logic [7:0] data;
    logic       k;
    logic       cerr;
    logic       derr;
    logic       rd;
  } dec_t;

  function automatic dec_t model_decode(input logic [9:0] sym, input logic rd_in);
    dec_t       o;
    logic [5:0] s6;
    logic [3:0] s4;
    int         n6, n4, x6, y4, yk;
    logic       k28pat, kx7;
    logic       r;
    s6 = sym[9:4];
    s4 = sym[3:0];
    n6 = $countones(s6);
    n4 = $countones(s4);
    x6 = -1; y4 = -1; yk = -1; kx7 = 1'b0;
    for (int x = 0; x < 32; x++) if (s6 == E6N[x] || s6 == E6P[x]) x6 = x;
    k28pat = (s6 == 6'b001111) || (s6 == 6'b110000);
    if (k28pat) x6 = 28;
    for (int y = 0; y < 8; y++) if (s4 == E4N[y] || s4 == E4P[y]) y4 = y;
    if (s4 == 4'b0111 || s4 == 4'b1000) y4 = 7;
    for (int y = 0; y < 8; y++) begin
      if (s6 == 6'b001111 && s4 == K4N[y]) yk = y;
      if (s6 == 6'b110000 && s4 == K4P[y]) yk = y;
    end
    for (int i = 0; i < 8; i++) if (sym == KX7[i]) kx7 = 1'b1;
    o.cerr = (n6 < 2) || (n6 > 4) || (n4 < 1) || (n4 > 3) || (x6 < 0) || (y4 < 0) ||
             (k28pat && yk < 0);
    if (k28pat && yk >= 0)     o.data = {yk[2:0], 5'd28};
    else if (x6 >= 0 && y4 >= 0) o.data = {y4[2:0], x6[4:0]};
    else                       o.data = 8'h00;
    o.k = !o.cerr && ((k28pat && yk >= 0) || kx7);
    r = rd_in;
    o.derr = 1'b0;
    if ((n6 > 3 && r) || (n6 < 3 && !r)) o.derr = 1'b1;
    if (n6 > 3 || s6 == 6'b000111) r = 1'b1;
    else if (n6 < 3 || s6 == 6'b111000) r = 1'b0;
    if ((n4 > 2 && r) || (n4 < 2 && !r)) o.derr = 1'b1;
    if (n4 > 2 || s4 == 4'b0011) r = 1'b1;
    else if (n4 < 2 || s4 == 4'b1100) r = 1'b0;
    o.rd = r;
    return o;
  endfunction

  logic clk = 1'b0;
  logic rst;
  decoder_8b10b_if bus();
  int n_tests = 0;
  int n_fail  = 0;

`ifdef DECODER_8B10B_ERR_CNT_EN
  logic       err_clr;
  logic [1:0] err_cnt;
  logic [1:0] m_cnt;
`endif

  decoder_8b10b #(.RD_INIT(RD_INIT), .ERR_CNT_W(2)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
`ifdef DECODER_8B10B_ERR_CNT_EN
    .err_cnt_clr_i (err_clr),
    .err_count_o   (err_cnt),
`endif
    .bus           (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model state, one cycle behind the inputs like the DUT.
  logic       m_valid, m_k, m_cerr, m_derr, m_rd;
  logic [7:0] m_data;
  dec_t       m_now;
  assign m_now = model_decode(bus.encoded_8b10b_symbol_i, m_rd);

  always @(posedge clk) begin
    if (rst) begin
      m_valid <= 1'b0; m_data <= 8'h00; m_k <= 1'b0;
      m_cerr  <= 1'b0; m_derr <= 1'b0;  m_rd <= RD_INIT;
    end else if (bus.valid_i) begin
      m_valid <= 1'b1; m_data <= m_now.data; m_k <= m_now.k;
      m_cerr  <= m_now.cerr; m_derr <= m_now.derr; m_rd <= m_now.rd;
    end else begin
      m_valid <= 1'b0; m_cerr <= 1'b0; m_derr <= 1'b0;
    end
`ifdef DECODER_8B10B_ERR_CNT_EN
    if (rst) m_cnt <= 2'd0;
    else if (err_clr) m_cnt <= 2'd0;
    else if (bus.valid_i && (m_now.cerr || m_now.derr) && m_cnt < 2'd3) m_cnt <= m_cnt + 2'd1;
`endif
  end

  always @(negedge clk) begin
    chk("model valid_o", {31'd0, bus.valid_o}, {31'd0, m_valid});
    chk("model data_o", {24'd0, bus.data_o}, {24'd0, m_data});
    chk("model is_special_k_o", {31'd0, bus.is_special_k_o}, {31'd0, m_k});
    chk("model code_err_o", {31'd0, bus.code_err_o}, {31'd0, m_cerr});
    chk("model disp_err_o", {31'd0, bus.disp_err_o}, {31'd0, m_derr});
    chk("model rd_o", {31'd0, bus.rd_o}, {31'd0, m_rd});
`ifdef DECODER_8B10B_ERR_CNT_EN
    chk("model err_count_o", {30'd0, err_cnt}, {30'd0, m_cnt});
`endif
  end

  // Apply inputs at a falling edge, return at the next falling edge so the
  // results of this cycle are visible on the outputs.
  task automatic step(input logic v, input logic [9:0] s, input logic r, input logic c);
    bus.valid_i = v;
    bus.encoded_8b10b_symbol_i = s;
    rst = r;
`ifdef DECODER_8B10B_ERR_CNT_EN
    err_clr = c;
`endif
    @(negedge clk);
  endtask

  // Literal expectation of all registered outputs.
  task automatic expect_out(input string tag, input logic v, input logic [7:0] d, input logic k,
                            input logic ce, input logic de, input logic rd);
    chk({tag, " valid_o"}, {31'd0, bus.valid_o}, {31'd0, v});
    chk({tag, " data_o"}, {24'd0, bus.data_o}, {24'd0, d});
    chk({tag, " k"}, {31'd0, bus.is_special_k_o}, {31'd0, k});
    chk({tag, " code_err"}, {31'd0, bus.code_err_o}, {31'd0, ce});
    chk({tag, " disp_err"}, {31'd0, bus.disp_err_o}, {31'd0, de});
    chk({tag, " rd_o"}, {31'd0, bus.rd_o}, {31'd0, rd});
  endtask

  initial begin
    logic [9:0] s;
    rst = 1'b1;
    bus.valid_i = 1'b0;
    bus.encoded_8b10b_symbol_i = 10'h000;
`ifdef DECODER_8B10B_ERR_CNT_EN
    err_clr = 1'b0;
`endif
    @(negedge clk);
    expect_out("reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    // K28.5 in both columns
    step(1'b1, 10'h0FA, 1'b0, 1'b0); expect_out("k28.5 rd-", 1'b1, 8'hBC, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 10'h305, 1'b0, 1'b0); expect_out("k28.5 rd+", 1'b1, 8'hBC, 1'b1, 1'b0, 1'b0, 1'b0);
    // Data characters
    step(1'b1, 10'h274, 1'b0, 1'b0); expect_out("d0.0", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 10'h2AA, 1'b0, 1'b0); expect_out("d21.5", 1'b1, 8'hB5, 1'b0, 1'b0, 1'b0, 1'b0);
    // Wrong-column K28.5 after reset, then resync
    step(1'b0, 10'h000, 1'b1, 1'b0);
    step(1'b1, 10'h305, 1'b0, 1'b0); expect_out("disp err", 1'b1, 8'hBC, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 10'h0FA, 1'b0, 1'b0); expect_out("resync", 1'b1, 8'hBC, 1'b1, 1'b0, 1'b0, 1'b1);
    // Illegal ones counts, then an idle gap
    step(1'b1, 10'h000, 1'b0, 1'b0); expect_out("all zero", 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 10'h3FF, 1'b0, 1'b0); expect_out("all one", 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 10'h155, 1'b0, 1'b0); expect_out("idle", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    // Mid-stream reset drops the in-flight symbol
    step(1'b1, 10'h305, 1'b0, 1'b0); expect_out("stream a", 1'b1, 8'hBC, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 10'h274, 1'b0, 1'b0); expect_out("stream b", 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 10'h0FA, 1'b1, 1'b0); expect_out("mid reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 10'h305, 1'b0, 1'b0); expect_out("post reset", 1'b1, 8'hBC, 1'b1, 1'b0, 1'b1, 1'b0);
    // Other control codes, alternate 7 form, D.x.3 in RD+, K28 with bad fghj
    step(1'b1, 10'h0F8, 1'b0, 1'b0); expect_out("k28.7", 1'b1, 8'hFC, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 10'h3A8, 1'b0, 1'b0); expect_out("k23.7", 1'b1, 8'hF7, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 10'h237, 1'b0, 1'b0); expect_out("d17.a7", 1'b1, 8'hF1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 10'h313, 1'b0, 1'b0); expect_out("d3.3", 1'b1, 8'h63, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b1, 10'h0FC, 1'b0, 1'b0); expect_out("k28 bad fghj", 1'b1, 8'h7C, 1'b0, 1'b1, 1'b1, 1'b0);

`ifdef DECODER_8B10B_ERR_CNT_EN
    step(1'b0, 10'h000, 1'b1, 1'b0);
    chk("cnt reset", {30'd0, err_cnt}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 10'h000, 1'b0, 1'b0);
      chk("cnt saturate", {30'd0, err_cnt}, (i < 3) ? i + 1 : 3);
    end
    step(1'b1, 10'h000, 1'b0, 1'b1);
    chk("cnt clear", {30'd0, err_cnt}, 32'd0);
    step(1'b1, 10'h3FF, 1'b0, 1'b0);
    chk("cnt after clear", {30'd0, err_cnt}, 32'd1);
`endif

    // Mixed stream: table-built symbols and raw patterns, checked by the model
    for (int i = 0; i < 400; i++) begin
      int x, y;
      x = $urandom_range(0, 31);
      y = $urandom_range(0, 7);
      case ($urandom_range(0, 3))
        0:       s = {E6N[x], E4N[y]};
        1:       s = {E6P[x], E4P[y]};
        2:       s = ($urandom_range(0, 1) != 0) ? {6'b001111, K4N[y]} : {6'b110000, K4P[y]};
        default: s = 10'($urandom_range(0, 1023));
      endcase
      step($urandom_range(0, 3) != 0, s, $urandom_range(0, 49) == 0, $urandom_range(0, 29) == 0);
    end

    step(1'b0, 10'h000, 1'b0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
